instr_prefetch_queue: RTL and testbench
=======================================

Name: instr_prefetch_queue

Overview:
Parametrised instruction prefetch queue for the multi-cycle 16-bit core.
- Fetches sequential instructions from instruction memory ahead of the decoder, using a single-outstanding req/ack handshake.
- Buffers fetched instructions, each with its PC, in a circular queue.
- Hands them to decode with a valid/ready handshake.
- Supports flush and redirect on branches and jumps, dropping any in-flight fetch that belongs to the old path.

Parameters:
ADDR_WIDTH, 13, instruction word address width; fetch PC wraps modulo 2^ADDR_WIDTH
INSTR_WIDTH, 16, instruction width
DEPTH, 4, queue entries; power of 2, minimum 2
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
mem_req  out  1  fetch request; held high until mem_ack
mem_addr  out  ADDR_WIDTH  fetch address; stable while mem_req is high
mem_ack  in  1  one-cycle pulse; mem_rdata is valid in the same cycle
mem_rdata  in  INSTR_WIDTH  fetched instruction
redirect  in  1  flush the queue and restart fetch at redirect_pc
redirect_pc  in  ADDR_WIDTH  new fetch address
dec_valid  out  1  head entry is available
dec_instr  out  INSTR_WIDTH  head instruction
dec_pc  out  ADDR_WIDTH  head instruction's PC
dec_ready  in  1  decoder accepts the head entry this cycle
occupancy  out  clog2(DEPTH)+1  valid entries in the queue

Behaviour:
- Reset values:
  - fetch_pc=RESET_PC; wr_ptr=rd_ptr=count=0.
  - FSM=IDLE; mem_req=0; mem_addr=RESET_PC.
  - dec_valid=0; dec_instr=0; dec_pc=0; occupancy=0.
  - Queue storage is not reset.
- Reset mid-request: all state clears. A later stray mem_ack while in IDLE is ignored.
- Fetch FSM states:
  - IDLE: if count<DEPTH and not redirect, set mem_req=1, mem_addr=fetch_pc, go to WAIT.
  - WAIT: on mem_ack:
    - push {mem_rdata, mem_addr} at wr_ptr; fetch_pc += 1, wrapping at 2^ADDR_WIDTH.
    - Go to IDLE with mem_req=0; there is at least one idle cycle between requests.
  - DRAIN: entered from WAIT when redirect is asserted without mem_ack.
    - mem_req and mem_addr stay held at the old values.
    - On mem_ack the data is discarded and the FSM goes to IDLE.
- Issue rule: count plus the one in-flight request never exceeds DEPTH. The FSM enters WAIT only if count<DEPTH, counted after any same-cycle pop.
- Decode side:
  - dec_valid = (count!=0). dec_instr and dec_pc are read combinationally from the rd_ptr entry.
  - Pop when dec_valid && dec_ready.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full: no pop, no request issued, and dec_valid stays high.
- Empty: dec_valid=0 and dec_ready is ignored.
- Pointer wrap: both pointers wrap modulo DEPTH.
- Redirect has priority over push and pop in the same cycle:
  - count, wr_ptr and rd_ptr clear to 0; fetch_pc=redirect_pc.
  - Any mem_ack in that same cycle is discarded.
  - A redirect in IDLE or WAIT-with-ack goes to IDLE. A redirect in WAIT without ack goes to DRAIN.
  - A redirect in DRAIN only updates fetch_pc.
- Redirect-to-decode latency:
  - dec_valid=0 the cycle after a redirect.
  - First new instruction earliest 3 cycles after the redirect when mem_ack returns in 1 cycle: IDLE→req, ack, then visible.
- occupancy = count, registered.

Optional Feature:
IPQ_PERF_COUNTERS_EN
- Defined: adds output perf_flush_cnt[15:0] and output perf_starve_cnt[15:0].
  - perf_flush_cnt counts redirect cycles.
  - perf_starve_cnt counts cycles with dec_ready=1 and dec_valid=0.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: neither port nor counter exists, and the block is otherwise identical.

Test Plan:
- Fill: reset, dec_ready=0, memory acks 1 cycle after req → addresses 0,1,2,3 fetched, occupancy reaches 4, mem_req stays 0 afterwards, dec_pc=0.
- Stream: dec_ready=1, 1-cycle memory → decoder receives PCs 0,1,2,… in order with no loss or duplication over 100 instructions; instr = mem[pc].
- Redirect in WAIT: req outstanding at addr 5, redirect_pc=0x40, ack 3 cycles later with data 0xDEAD → 0xDEAD never reaches decode; next mem_addr=0x40; occupancy=0 after the redirect.
- Redirect with simultaneous ack and pop: occupancy=2 → occupancy=0 next cycle; the acked data is dropped; fetch resumes at redirect_pc.
- Wrap: redirect_pc=0x1FFE with ADDR_WIDTH=13 → fetched PCs are 0x1FFE, 0x1FFF, 0x0000; the queue pointers wrap correctly across 3×DEPTH pushes.
- Async reset asserted while mem_req=1 and occupancy=3 → all outputs go to reset values immediately; the first post-reset mem_addr=RESET_PC; with IPQ_PERF_COUNTERS_EN defined, both counters read 0.

Source files
------------

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential instructions ahead of decode
// over a single-outstanding req/ack memory port, buffers {instr, pc} entries
// in a circular queue, and supports redirect with in-flight fetch discard.
// Optional macro IPQ_PERF_COUNTERS_EN adds saturating flush/starve counters.
module instr_prefetch_queue #(
  parameter int ADDR_WIDTH  = 13,
  parameter int INSTR_WIDTH = 16,
  parameter int DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_req,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  input  logic                     mem_ack,
  input  logic [INSTR_WIDTH-1:0]   mem_rdata,
  input  logic                     redirect,
  input  logic [ADDR_WIDTH-1:0]    redirect_pc,
  output logic                     dec_valid,
  output logic [INSTR_WIDTH-1:0]   dec_instr,
  output logic [ADDR_WIDTH-1:0]    dec_pc,
  input  logic                     dec_ready,
  output logic [$clog2(DEPTH):0]   occupancy
`ifdef IPQ_PERF_COUNTERS_EN
  ,
  output logic [15:0]              perf_flush_cnt,
  output logic [15:0]              perf_starve_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   fetch_pc_reg, fetch_pc_next;
  logic [PW-1:0]           wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]           rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]           count_reg, count_next;
  logic                    mem_req_reg, mem_req_next;
  logic [ADDR_WIDTH-1:0]   mem_addr_reg, mem_addr_next;
  logic                    push;
  logic                    pop;

  logic [INSTR_WIDTH-1:0]  instr_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   pc_mem    [DEPTH];

  // Queue storage, one register pair per entry; contents are not reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_reg == PW'(gi))) begin
        instr_mem[gi] <= mem_rdata;
        pc_mem[gi]    <= mem_addr_reg;
      end
    end
  end

  assign dec_valid = (count_reg != '0);
  assign dec_instr = dec_valid ? instr_mem[rd_ptr_reg] : '0;
  assign dec_pc    = dec_valid ? pc_mem[rd_ptr_reg]    : '0;
  assign pop       = dec_valid && dec_ready;
  assign mem_req   = mem_req_reg;
  assign mem_addr  = mem_addr_reg;
  assign occupancy = count_reg;

  // Fetch FSM next state plus queue bookkeeping; redirect overrides push/pop.
  always_comb begin
    state_next    = state_reg;
    mem_req_next  = mem_req_reg;
    mem_addr_next = mem_addr_reg;
    fetch_pc_next = fetch_pc_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    push          = 1'b0;

    case (state_reg)
      IDLE: begin
        // Space is judged after this cycle's pop so a full queue that is
        // being drained can still issue without exceeding DEPTH.
        if (!redirect && ((count_reg < DEPTH_C) || pop)) begin
          state_next    = WAIT;
          mem_req_next  = 1'b1;
          mem_addr_next = fetch_pc_reg;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          state_next   = IDLE;
          mem_req_next = 1'b0;
          push         = !redirect;
        end else if (redirect) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Old-path response is swallowed; request stays held until it lands.
        if (mem_ack) begin
          state_next   = IDLE;
          mem_req_next = 1'b0;
        end
      end
      default: begin
        state_next   = IDLE;
        mem_req_next = 1'b0;
      end
    endcase

    if (redirect) begin
      fetch_pc_next = redirect_pc;
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      count_next    = '0;
    end else begin
      if (push) begin
        wr_ptr_next   = wr_ptr_reg + PW'(1);
        fetch_pc_next = fetch_pc_reg + ADDR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PW'(1);
      end
      count_next = count_reg + CW'(push) - CW'(pop);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      mem_req_reg  <= 1'b0;
      mem_addr_reg <= RESET_PC;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      mem_req_reg  <= mem_req_next;
      mem_addr_reg <= mem_addr_next;
    end
  end

`ifdef IPQ_PERF_COUNTERS_EN
  // Saturating counters for redirect cycles and decoder starvation cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_flush_cnt  <= '0;
      perf_starve_cnt <= '0;
    end else begin
      if (redirect && (perf_flush_cnt != 16'hFFFF)) begin
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
      end
      if (dec_ready && !dec_valid && (perf_starve_cnt != 16'hFFFF)) begin
        perf_starve_cnt <= perf_starve_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Randomized bench for instr_prefetch_queue: a queue-based reference model
// plus a responding memory; scenario tasks add targeted inline checks.
module tb_instr_prefetch_queue;

  localparam int AW    = 13;
  localparam int IW    = 16;
  localparam int DEPTH = 4;
  localparam int OW    = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] RESET_PC = '0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mem_req, mem_ack;
  logic [AW-1:0] mem_addr, redirect_pc, dec_pc;
  logic [IW-1:0] mem_rdata, dec_instr;
  logic redirect, dec_valid, dec_ready;
  logic [OW-1:0] occupancy;
`ifdef IPQ_PERF_COUNTERS_EN
  logic [15:0] perf_flush_cnt, perf_starve_cnt;
`endif

  instr_prefetch_queue #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_ready(dec_ready),
    .occupancy(occupancy)
`ifdef IPQ_PERF_COUNTERS_EN
    , .perf_flush_cnt(perf_flush_cnt), .perf_starve_cnt(perf_starve_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {logic [AW-1:0] pc; logic [IW-1:0] instr;} ent_t;

  // Reference model state (value after the most recent modelled clock edge)
  ent_t          q[$];
  logic          m_req, m_stale;
  logic [AW-1:0] m_addr, m_fpc;
  logic [15:0]   m_flush, m_starve;
  int            wait_cnt, ack_lat, lat_fix, lat_max;
  logic          poison, stray_ack, mon_en;
  ent_t          dut_log[$];
  logic [AW-1:0] fetch_log[$];
  int            vectors, miscompares;

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return {a, 3'b101} ^ 16'h6A3C;
  endfunction

  task automatic model_reset();
    q.delete(); dut_log.delete(); fetch_log.delete();
    m_req = 1'b0; m_stale = 1'b0; m_addr = RESET_PC; m_fpc = RESET_PC;
    m_flush = '0; m_starve = '0; wait_cnt = 0; ack_lat = 0;
    redirect = 1'b0; dec_ready = 1'b0; redirect_pc = '0; mem_ack = 1'b0; mem_rdata = '0;
  endtask

  // Drive one cycle's inputs and advance the model across the coming edge.
  task automatic drive_update(input logic rd, input logic rdy, input logic [AW-1:0] rpc);
    logic ack, pop, push, n_req;
    int sz;
    ack = stray_ack || (m_req && (wait_cnt >= ack_lat));
    redirect = rd; dec_ready = rdy; redirect_pc = rpc; mem_ack = ack;
    mem_rdata = !ack ? IW'($urandom) : (poison ? 16'hDEAD : mem_word(mem_addr));
    if (ack && mem_req) fetch_log.push_back(mem_addr);
    if (dec_valid && rdy && !rd) begin
      dut_log.push_back('{pc: dec_pc, instr: dec_instr});
      $display("decode pc=%h instr=%h occ=%0d", dec_pc, dec_instr, occupancy);
    end
    sz    = q.size();
    pop   = (sz != 0) && rdy;
    push  = m_req && ack && !rd && !m_stale;
    n_req = m_req ? !ack : (!rd && ((sz - int'(pop)) < DEPTH));
    if (rd && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
    if (rdy && sz == 0 && m_starve != 16'hFFFF) m_starve = m_starve + 16'd1;
    if (m_req && ack) m_stale = 1'b0;
    if (m_req && !ack && rd) m_stale = 1'b1;
    if (rd) begin
      q.delete();
      m_fpc = rpc;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back('{pc: m_addr, instr: mem_word(m_addr)});
        m_fpc = m_addr + AW'(1);
      end
    end
    if (m_req) wait_cnt = ack ? 0 : wait_cnt + 1;
    if (!m_req && n_req) begin
      m_addr   = m_fpc;
      wait_cnt = 0;
      ack_lat  = (lat_fix >= 0) ? lat_fix : int'($urandom_range(lat_max, 0));
    end
    m_req = n_req;
  endtask

  task automatic sync();
    @(negedge clk); #1;
  endtask

  task automatic step(input logic rd, input logic rdy, input logic [AW-1:0] rpc);
    sync();
    drive_update(rd, rdy, rpc);
  endtask

  // Cycle-by-cycle scoreboard against the model
  always @(negedge clk) begin
    if (mon_en) begin
      vectors++;
      if (mem_req !== m_req) begin
        miscompares++; $display("FAIL mon_mem_req got %b want %b at %0t", mem_req, m_req, $time);
      end
      if (m_req) begin
        vectors++;
        if (mem_addr !== m_addr) begin
          miscompares++; $display("FAIL mon_mem_addr got %h want %h at %0t", mem_addr, m_addr, $time);
        end
      end
      vectors++;
      if (occupancy !== OW'(q.size())) begin
        miscompares++; $display("FAIL mon_occupancy got %0d want %0d at %0t", occupancy, q.size(), $time);
      end
      vectors++;
      if (dec_valid !== (q.size() != 0)) begin
        miscompares++; $display("FAIL mon_dec_valid got %b want %b at %0t", dec_valid, q.size() != 0, $time);
      end
      if (q.size() != 0) begin
        vectors++;
        if (dec_pc !== q[0].pc || dec_instr !== q[0].instr) begin
          miscompares++;
          $display("FAIL mon_head got %h/%h want %h/%h at %0t", dec_pc, dec_instr, q[0].pc, q[0].instr, $time);
        end
      end
`ifdef IPQ_PERF_COUNTERS_EN
      vectors++;
      if (perf_flush_cnt !== m_flush || perf_starve_cnt !== m_starve) begin
        miscompares++;
        $display("FAIL mon_perf got %0d/%0d want %0d/%0d", perf_flush_cnt, perf_starve_cnt, m_flush, m_starve);
      end
`endif
    end
  end

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (mem_req !== 1'b0 || mem_addr !== RESET_PC || dec_valid !== 1'b0 ||
        dec_instr !== '0 || dec_pc !== '0 || occupancy !== '0) begin
      miscompares++;
      $display("FAIL reset_values got req=%b addr=%h v=%b i=%h pc=%h occ=%0d want zeros", mem_req, mem_addr, dec_valid, dec_instr, dec_pc, occupancy);
    end
`ifdef IPQ_PERF_COUNTERS_EN
    vectors++;
    if (perf_flush_cnt !== 16'd0 || perf_starve_cnt !== 16'd0) begin
      miscompares++; $display("FAIL reset_perf got %0d/%0d want 0/0", perf_flush_cnt, perf_starve_cnt);
    end
`endif
    sync();
    rst = 1'b1;
    stray_ack = 1'b1;
    drive_update(1'b0, 1'b0, '0);
    stray_ack = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (occupancy !== '0 || mem_req !== 1'b1 || mem_addr !== RESET_PC) begin
      miscompares++; $display("FAIL stray_ack got occ=%0d req=%b addr=%h want 0/1/%h", occupancy, mem_req, mem_addr, RESET_PC);
    end
  endtask

  task automatic test_fill();
    lat_fix = 0;
    repeat (20) step(1'b0, 1'b0, '0);
    @(posedge clk); #1;
    vectors++;
    if (occupancy !== OW'(DEPTH) || mem_req !== 1'b0 || dec_pc !== '0 || dec_instr !== mem_word('0)) begin
      miscompares++; $display("FAIL fill got occ=%0d req=%b pc=%h want 4/0/0", occupancy, mem_req, dec_pc);
    end
    vectors++;
    if (fetch_log.size() != DEPTH) begin
      miscompares++; $display("FAIL fill_count got %0d want %0d", fetch_log.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        vectors++;
        if (fetch_log[i] !== AW'(i)) begin
          miscompares++; $display("FAIL fill_addr got %h want %h", fetch_log[i], AW'(i));
        end
      end
    end
  endtask

  task automatic test_stream();
    int n;
    lat_fix = -1; lat_max = 2; n = 0;
    while (dut_log.size() < 100 && n < 2000) begin
      step(1'b0, 1'b1, '0);
      n++;
    end
    vectors++;
    if (dut_log.size() < 100) begin
      miscompares++; $display("FAIL stream_timeout got %0d want 100", dut_log.size());
    end
    for (int i = 0; i < dut_log.size() && i < 100; i++) begin
      vectors++;
      if (dut_log[i].pc !== AW'(i) || dut_log[i].instr !== mem_word(AW'(i))) begin
        miscompares++; $display("FAIL stream_order got %h/%h want %h/%h", dut_log[i].pc, dut_log[i].instr, AW'(i), mem_word(AW'(i)));
      end
    end
  endtask

  task automatic test_redirect_wait();
    int n, base;
    lat_fix = 3; n = 0;
    step(1'b1, 1'b0, AW'(5));
    sync();
    while (!(mem_req && mem_addr == AW'(5) && !m_stale && wait_cnt == 0) && n < 40) begin
      drive_update(1'b0, 1'b0, '0); sync(); n++;
    end
    vectors++;
    if (n >= 40) begin
      miscompares++; $display("FAIL rw_setup got timeout want req at 005");
    end
    poison = 1'b1;
    drive_update(1'b1, 1'b0, AW'('h40));
    @(posedge clk); #1;
    vectors++;
    if (occupancy !== '0 || dec_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== AW'(5)) begin
      miscompares++; $display("FAIL rw_drain got occ=%0d v=%b req=%b addr=%h want 0/0/1/005", occupancy, dec_valid, mem_req, mem_addr);
    end
    base = dut_log.size(); n = 0;
    sync();
    while (mem_req && n < 20) begin drive_update(1'b0, 1'b1, '0); sync(); n++; end
    poison = 1'b0; lat_fix = 0;
    while (!mem_req && n < 40) begin drive_update(1'b0, 1'b1, '0); sync(); n++; end
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== AW'('h40)) begin
      miscompares++; $display("FAIL rw_new_addr got req=%b addr=%h want 1/040", mem_req, mem_addr);
    end
    drive_update(1'b0, 1'b1, '0);
    repeat (6) step(1'b0, 1'b1, '0);
    vectors++;
    if (dut_log.size() <= base || dut_log[base].pc !== AW'('h40) || dut_log[base].instr !== mem_word(AW'('h40))) begin
      miscompares++; $display("FAIL rw_first got n=%0d want pc 040 instr %h", dut_log.size() - base, mem_word(AW'('h40)));
    end
    foreach (dut_log[i]) begin
      vectors++;
      if (dut_log[i].instr === 16'hDEAD) begin
        miscompares++; $display("FAIL rw_stale got %h want none at pc %h", dut_log[i].instr, dut_log[i].pc);
      end
    end
  endtask

  task automatic test_redirect_ack_pop();
    int n;
    lat_fix = 1; n = 0;
    step(1'b1, 1'b0, AW'('h100));
    sync();
    while (!(occupancy == OW'(2) && mem_req && !m_stale && wait_cnt == 1) && n < 40) begin
      drive_update(1'b0, 1'b0, '0); sync(); n++;
    end
    vectors++;
    if (n >= 40) begin
      miscompares++; $display("FAIL rap_setup got timeout want occ 2 with ack due");
    end
    lat_fix = 0;
    drive_update(1'b1, 1'b1, AW'('h200));
    @(posedge clk); #1;
    vectors++;
    if (occupancy !== '0 || dec_valid !== 1'b0 || mem_req !== 1'b0) begin
      miscompares++; $display("FAIL rap_clear got occ=%0d v=%b req=%b want 0/0/0", occupancy, dec_valid, mem_req);
    end
    step(1'b0, 1'b0, '0);
    @(posedge clk); #1;
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== AW'('h200) || dec_valid !== 1'b0) begin
      miscompares++; $display("FAIL rap_req got req=%b addr=%h v=%b want 1/200/0", mem_req, mem_addr, dec_valid);
    end
    step(1'b0, 1'b0, '0);
    @(posedge clk); #1;
    vectors++;
    if (dec_valid !== 1'b1 || dec_pc !== AW'('h200) || dec_instr !== mem_word(AW'('h200)) || occupancy !== OW'(1)) begin
      miscompares++; $display("FAIL rap_latency got v=%b pc=%h occ=%0d want 1/200/1", dec_valid, dec_pc, occupancy);
    end
  endtask

  task automatic test_wrap();
    int n, base;
    logic [AW-1:0] exp_pc;
    lat_fix = -1; lat_max = 2; n = 0;
    step(1'b1, 1'b0, AW'('h1FFE));
    base = dut_log.size();
    while ((dut_log.size() - base) < 3 * DEPTH + 2 && n < 1000) begin
      step(1'b0, 1'($urandom), '0);
      n++;
    end
    vectors++;
    if ((dut_log.size() - base) < 3 * DEPTH + 2) begin
      miscompares++; $display("FAIL wrap_timeout got %0d want %0d", dut_log.size() - base, 3 * DEPTH + 2);
    end
    exp_pc = AW'('h1FFE);
    for (int i = base; i < dut_log.size(); i++) begin
      vectors++;
      if (dut_log[i].pc !== exp_pc || dut_log[i].instr !== mem_word(exp_pc)) begin
        miscompares++; $display("FAIL wrap_pc got %h/%h want %h/%h", dut_log[i].pc, dut_log[i].instr, exp_pc, mem_word(exp_pc));
      end
      exp_pc = exp_pc + AW'(1);
    end
  endtask

  task automatic test_random();
    lat_fix = -1; lat_max = 3;
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 20) == 0, 1'($urandom), AW'($urandom));
    end
    @(posedge clk); #1;
    vectors++;
    if (occupancy > OW'(DEPTH)) begin
      miscompares++; $display("FAIL random_bound got %0d want <= %0d", occupancy, DEPTH);
    end
  endtask

  task automatic test_async_reset();
    int n;
    lat_fix = 3; n = 0;
    step(1'b1, 1'b0, AW'('h10));
    sync();
    while (!(occupancy == OW'(3) && mem_req) && n < 60) begin
      drive_update(1'b0, 1'b0, '0); sync(); n++;
    end
    vectors++;
    if (n >= 60) begin
      miscompares++; $display("FAIL ar_setup got timeout want occ 3 with req");
    end
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    vectors++;
    if (mem_req !== 1'b0 || mem_addr !== RESET_PC || dec_valid !== 1'b0 ||
        dec_instr !== '0 || dec_pc !== '0 || occupancy !== '0) begin
      miscompares++;
      $display("FAIL ar_values got req=%b addr=%h v=%b i=%h pc=%h occ=%0d want zeros", mem_req, mem_addr, dec_valid, dec_instr, dec_pc, occupancy);
    end
`ifdef IPQ_PERF_COUNTERS_EN
    vectors++;
    if (perf_flush_cnt !== 16'd0 || perf_starve_cnt !== 16'd0) begin
      miscompares++; $display("FAIL ar_perf got %0d/%0d want 0/0", perf_flush_cnt, perf_starve_cnt);
    end
`endif
    model_reset();
    lat_fix = 0;
    repeat (2) @(posedge clk);
    sync();
    rst = 1'b1;
    drive_update(1'b0, 1'b0, '0);
    mon_en = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== RESET_PC) begin
      miscompares++; $display("FAIL ar_first got req=%b addr=%h want 1/%h", mem_req, mem_addr, RESET_PC);
    end
    repeat (10) step(1'b0, 1'($urandom), '0);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    mon_en = 1'b0; poison = 1'b0; stray_ack = 1'b0;
    lat_fix = 0; lat_max = 0;
    test_reset();
    test_fill();
    test_stream();
    test_redirect_wait();
    test_redirect_ack_pop();
    test_wrap();
    test_random();
    test_async_reset();
    sync();
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
